// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for apb_master_bridge.
// The bridge takes the master view; the environment (bench or slaves) takes the slave view.
interface apb_master_bridge_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [DATA_W-1:0]         cmd_wdata;
  logic [STRB_W-1:0]         cmd_strb;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [ADDR_W-1:0]         PADDR;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [DATA_W-1:0]         PWDATA;
  logic [STRB_W-1:0]         PSTRB;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 master: one command in, one APB transfer out, one response back.
// Slave select is decoded from an address field; a wait-state timeout aborts hung transfers.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SEL_W:0]   NUM_SLV_C = (SEL_W + 1)'(NUM_SLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [SEL_W-1:0]    cmd_idx;
  logic                cmd_decode_ok;
  logic [NUM_SLV-1:0]  cmd_onehot;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  assign cmd_idx       = bus.cmd_addr[SEL_LSB +: SEL_W];
  assign cmd_decode_ok = ({1'b0, cmd_idx} < NUM_SLV_C);

  // PSEL is one-hot while a transfer is live, so it doubles as the return-path mux select.
  always_comb begin
    cmd_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      cmd_onehot[i] = (cmd_idx == SEL_W'(i));
      if (psel_q[i]) begin
        sel_ready = bus.PREADY[i];
        sel_err   = bus.PSLVERR[i];
        sel_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts as a hold of its _q so no path through the case leaves one unassigned (no latches).
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_wdata;
          pstrb_d     = bus.cmd_write ? bus.cmd_strb : '0;
          cnt_d       = '0;
          if (cmd_decode_ok) begin
            psel_d  = cmd_onehot;
            state_d = SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // The abort check comes first so a late PREADY in the final allowed cycle still loses.
        if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else if (sel_ready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge with three slaves, so slave index 3 is a decode error.
// Expected latency, PSEL, data and error come from a transaction-level model of the bridge rules.
module tb_apb_master_bridge;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 3;
  localparam int SEL_LSB = 12;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK   (clk),
    .PRESETn(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check({tag, "_rsp_err"},   bus.rsp_err, 0);
    check({tag, "_psel"},      bus.PSEL, 0);
    check({tag, "_penable"},   bus.PENABLE, 0);
    check({tag, "_pwrite"},    bus.PWRITE, 0);
    check({tag, "_paddr"},     bus.PADDR, 0);
    check({tag, "_pwdata"},    bus.PWDATA, 0);
    check({tag, "_pstrb"},     bus.PSTRB, 0);
  endtask

  // Unselected slaves get random garbage; the addressed slave gets the given values.
  task automatic drive_slaves(input int idx, input bit rdy, input bit err, input logic [31:0] rdata);
    bus.PREADY  = NUM_SLV'($urandom);
    bus.PSLVERR = NUM_SLV'($urandom);
    for (int i = 0; i < NUM_SLV; i++) bus.PRDATA[i*DATA_W +: DATA_W] = $urandom;
    if (idx < NUM_SLV) begin
      bus.PREADY[idx]  = rdy;
      bus.PSLVERR[idx] = err;
      bus.PRDATA[idx*DATA_W +: DATA_W] = rdata;
    end
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int wait_n, input bit slverr,
                         input logic [31:0] rdata, input int hold);
    int idx, n_acc, exp_rsp, cyc, first_sel, first_en, en_cnt, rsp_cyc, t;
    bit dec_err, abort, exp_err;
    logic [31:0] exp_data;
    logic [2:0]  exp_sel;
    logic [3:0]  exp_strb;

    idx      = int'(addr[SEL_LSB +: 2]);
    dec_err  = (idx >= NUM_SLV);
    abort    = !dec_err && (TIMEOUT != 0) && (wait_n + 1 >= TIMEOUT);
    n_acc    = dec_err ? 0 : (abort ? TIMEOUT : wait_n + 1);
    exp_err  = dec_err || abort || slverr;
    exp_data = (exp_err || wr) ? 32'h0 : rdata;
    exp_rsp  = dec_err ? 1 : 2 + n_acc;
    exp_sel  = dec_err ? 3'b000 : 3'(1 << idx);
    exp_strb = wr ? strb : 4'h0;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_strb  = strb;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("cmd_accept", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = 4'($urandom);

    cyc = 1; first_sel = -1; first_en = -1; en_cnt = 0; rsp_cyc = -1;
    while (rsp_cyc < 0 && cyc < 60) begin
      if (bus.PSEL != 0) begin
        if (first_sel < 0) first_sel = cyc;
        check("psel_value", bus.PSEL, exp_sel);
        check("paddr_hold", bus.PADDR, addr);
        check("pwrite_hold", bus.PWRITE, wr);
        check("pwdata_hold", bus.PWDATA, data);
        check("pstrb_hold", bus.PSTRB, exp_strb);
      end
      if (bus.PENABLE) begin
        if (first_en < 0) first_en = cyc;
        en_cnt++;
      end
      if (bus.rsp_valid) begin
        rsp_cyc = cyc;
      end else begin
        if (bus.PENABLE) drive_slaves(idx, en_cnt > wait_n, (en_cnt > wait_n) ? slverr : 1'($urandom), rdata);
        else             drive_slaves(idx, 1'($urandom), 1'($urandom), $urandom);
        @(posedge clk); #1; cyc++;
      end
    end

    check("rsp_seen", rsp_cyc >= 0, 1);
    check("lat_psel", first_sel, dec_err ? -1 : 1);
    check("lat_penable", first_en, dec_err ? -1 : 2);
    check("penable_cycles", en_cnt, n_acc);
    check("lat_rsp", rsp_cyc, exp_rsp);
    check("rsp_psel_low", bus.PSEL, 0);
    check("rsp_rdata", bus.rsp_rdata, exp_data);
    check("rsp_err", bus.rsp_err, exp_err);

    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      drive_slaves(idx, 1'($urandom), 1'($urandom), $urandom);
      @(posedge clk); #1;
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_rdata", bus.rsp_rdata, exp_data);
      check("hold_err", bus.rsp_err, exp_err);
      check("hold_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_drop", bus.rsp_valid, 0);
    check("idle_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    int t;
    logic [31:0] a;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = '0;
    bus.PSLVERR   = '0;
    bus.PRDATA    = '0;

    #1;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_held_cmd_ready", bus.cmd_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_cmd_ready", bus.cmd_ready, 1);

    run_txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h0000_2008, 32'h0BAD_F00D, 4'hA, 3, 1'b0, 32'h1234_5678, 0);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 1'b1, 32'hCAFE_0001, 1);
    run_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 100, 1'b0, 32'h5555_AAAA, 0);
    run_txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, TIMEOUT - 2, 1'b0, 32'h7777_1111, 0);
    run_txn(1'b1, 32'h0000_1000, 32'h1357_9BDF, 4'h3, TIMEOUT - 1, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 1'b0, 32'h9999_9999, 2);
    run_txn(1'b1, 32'hFFFF_3FFC, 32'h2468_ACE0, 4'h5, 0, 1'b0, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      run_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 18), 1'($urandom),
              $urandom, $urandom_range(0, 3));
    end

    run_txn(1'b0, 32'h0000_2004, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_5A5A, 5);

    // Reset in the middle of an ACCESS phase: the transfer is dropped without a response.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_1008;
    bus.cmd_wdata = 32'hFEED_FACE;
    bus.cmd_strb  = 4'hF;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.PREADY    = '0;
    t = 0;
    while (bus.PENABLE !== 1'b1 && t < 10) begin
      @(posedge clk); #1; t++;
    end
    check("mid_access_reached", bus.PENABLE, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_cmd_ready", bus.cmd_ready, 1);
    for (int c = 0; c < 4; c++) begin
      check("after_reset_no_rsp", bus.rsp_valid, 0);
      check("after_reset_psel", bus.PSEL, 0);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
